// File: rtl/dm_sized.sv
// Byte-addressed little-endian data memory with sized loads and stores,
// error detection, a valid/ready request path and a one-entry response buffer.
module dm_sized #(
    parameter int          DEPTH    = 100,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] ERR_CODE = 32'h0000DEAD,
    parameter int          ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(4 * DEPTH);

    logic [31:0] mem_q [DEPTH];

    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept;
    logic             req_err;
    logic             wr_en;
    logic [IDX_W-1:0] widx;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_data;

    assign req_ready = rst_n && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign lane      = req_addr[1:0];
    assign widx      = req_addr[IDX_W+1:2];
    assign wr_en     = accept && req_we && !req_err;

    always_comb begin
        req_err = 1'b0;
        if ({1'b0, req_addr} >= LIMIT) req_err = 1'b1;
        case (req_size)
            2'd1:    if (req_addr[0]) req_err = 1'b1;
            2'd2:    if (lane != 2'd0) req_err = 1'b1;
            2'd3:    req_err = 1'b1;
            default: ;
        endcase
    end

    // Out-of-range indices are only ever read when req_err masks the result.
    always_comb begin
        rd_word  = mem_q[widx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (req_size)
            2'd0: ld_data = req_unsigned ? {24'd0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1: ld_data = req_unsigned ? {16'd0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        wdata_sh = req_wdata << {lane, 3'b000};
        case (req_size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem_q[widx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            if (req_we)       rsp_rdata_d = 32'd0;
            else if (req_err) rsp_rdata_d = ERR_CODE;
            else              rsp_rdata_d = ld_data;
            if (req_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized against a byte-array reference model.
// Directed scenarios followed by randomized back-to-back traffic.
module tb_dm_sized;

    localparam int          DEPTH    = 100;
    localparam int          ADDR_W   = 32;
    localparam int          ERRCNT_W = 2;
    localparam logic [31:0] ERR_CODE = 32'h0000DEAD;
    localparam int          CNT_MAX  = (1 << ERRCNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [ERRCNT_W-1:0] err_cnt;

    dm_sized #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ERR_CODE(ERR_CODE),
        .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: byte-granular memory and error count.
    logic [7:0]  mem_m [4*DEPTH];
    int          cnt_m;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        rdy_seen;
    int          checks;
    int          errors;

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n;
        logic [31:0] v;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_err = (size == 2'd3) || (addr >= 32'(4 * DEPTH)) || ((addr % n) != 0);
        v = 32'd0;
        if (exp_err) begin
            v = we ? 32'd0 : ERR_CODE;
            if (cnt_m < CNT_MAX) cnt_m++;
        end else if (we) begin
            for (int i = 0; i < n; i++) mem_m[addr + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[addr + i]) << (8 * i));
            if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        end
        exp_rd = v;
    endtask

    // Drive one request (called at a negedge); returns at the next negedge.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        rsp_ready    = 1'b1;
        #1 rdy_seen = req_ready;
        @(posedge clk);
        model(we, size, uns, addr, wd);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || err_cnt !== '0 || req_ready !== 1'b0 ||
            rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b cnt=%0d ready=%b rdata=%h err=%b, expected 0 0 0 0 0",
                     rsp_valid, err_cnt, req_ready, rsp_rdata, rsp_err);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
        cnt_m = 0;
    endtask

    task automatic test_fill;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            send(1'b1, 2'd2, 1'b0, 32'(4 * i), d);
            checks++;
            if (rdy_seen !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL fill_store[%0d]: ready=%b valid=%b rdata=%h err=%b, expected 1 1 0 0",
                         i, rdy_seen, rsp_valid, rsp_rdata, rsp_err);
            end
        end
    endtask

    task automatic test_word;
        send(1'b1, 2'd2, 1'b0, 32'd8, 32'h8899AABB);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL word_store_rsp: valid=%b rdata=%h err=%b, expected 1 0 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        send(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8899AABB || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL word_load: valid=%b rdata=%h err=%b, expected 1 8899aabb 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL word_rsp_one_cycle: valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_byte;
        logic [1:0]  sz [4];
        logic        un [4];
        logic [31:0] ad [4];
        logic [31:0] ex [4];
        sz = '{2'd2, 2'd0, 2'd0, 2'd1};
        un = '{1'b0, 1'b0, 1'b1, 1'b0};
        ad = '{32'd8, 32'd9, 32'd9, 32'd10};
        ex = '{32'h8899F0BB, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8899};
        send(1'b1, 2'd0, 1'b0, 32'd9, 32'h000000F0);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, sz[i], un[i], ad[i], 32'd0);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ex[i] || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL sized_load[%0d]: valid=%b rdata=%h err=%b, expected 1 %h 0",
                         i, rsp_valid, rsp_rdata, rsp_err, ex[i]);
            end
        end
    endtask

    task automatic test_errors;
        send(1'b0, 2'd2, 1'b0, 32'd6, 32'd0);
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL err_misaligned: err=%b rdata=%h, expected 1 0000dead", rsp_err, rsp_rdata);
        end
        send(1'b1, 2'd2, 1'b0, 32'd400, 32'h12345678);
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL err_range_store: err=%b rdata=%h, expected 1 0", rsp_err, rsp_rdata);
        end
        send(1'b0, 2'd3, 1'b0, 32'd0, 32'd0);
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL err_size3: err=%b rdata=%h, expected 1 0000dead", rsp_err, rsp_rdata);
        end
        checks++;
        if (err_cnt !== 2'd3) begin
            errors++;
            $display("FAIL err_cnt_three: got %0d expected 3", err_cnt);
        end
        send(1'b0, 2'd2, 1'b0, 32'd396, 32'd0);
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL range_unchanged: err=%b rdata=%h, expected 0 %h", rsp_err, rsp_rdata, exp_rd);
        end
        send(1'b1, 2'd2, 1'b0, 32'd9, 32'h0BADF00D);
        send(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h8899F0BB) begin
            errors++;
            $display("FAIL misaligned_store_blocked: err=%b rdata=%h, expected 0 8899f0bb",
                     rsp_err, rsp_rdata);
        end
        send(1'b1, 2'd3, 1'b0, 32'd4, 32'd0);
        checks++;
        if (err_cnt !== 2'd3 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_cnt_saturate: cnt=%0d err=%b, expected 3 1", err_cnt, rsp_err);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] ea;
        logic [31:0] d;
        d = $urandom;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'd8;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;
        @(posedge clk);
        model(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
        ea = exp_rd;
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 32'd12;
        req_wdata = d;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ea || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, expected 1 %h 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, ea);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        model(1'b1, 2'd2, 1'b0, 32'd12, d);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store: valid=%b rdata=%h err=%b, expected 1 0 0", rsp_valid, rsp_rdata, rsp_err);
        end
        req_we = 1'b0;
        @(posedge clk);
        model(1'b0, 2'd2, 1'b0, 32'd12, 32'd0);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== d || rsp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL b2b_load: valid=%b rdata=%h, expected 1 %h", rsp_valid, rsp_rdata, d);
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        d = $urandom;
        send(1'b1, 2'd2, 1'b0, 32'd20, d);
        send(1'b0, 2'd2, 1'b0, 32'd20, 32'd0);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        cnt_m = 0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || err_cnt !== '0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b ready=%b cnt=%0d rdata=%h, expected 0 0 0 0",
                     rsp_valid, req_ready, err_cnt, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 2'd2, 1'b0, 32'd20, 32'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== d || rsp_err !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_keeps_array: valid=%b rdata=%h err=%b cnt=%0d, expected 1 %h 0 0",
                     rsp_valid, rsp_rdata, rsp_err, err_cnt, d);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] ad;
        int          r;
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            un = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 19);
            if (r == 0)      ad = $urandom;
            else if (r == 1) ad = 32'(400 + $urandom_range(0, 20));
            else             ad = 32'($urandom_range(0, 399));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            send(we, sz, un, ad, $urandom);
            checks++;
            if (rdy_seen !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== exp_rd ||
                rsp_err !== exp_err || err_cnt !== ERRCNT_W'(cnt_m)) begin
                errors++;
                $display("FAIL rand[%0d] we=%b sz=%0d un=%b a=%h: rdy=%b v=%b rd=%h e=%b c=%0d, expected 1 1 %h %b %0d",
                         i, we, sz, un, ad, rdy_seen, rsp_valid, rsp_rdata, rsp_err, err_cnt,
                         exp_rd, exp_err, cnt_m);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        cnt_m        = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) mem_m[i] = 8'd0;
        test_reset;
        test_fill;
        test_word;
        test_byte;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
